// File: rtl/dpwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dpwm_pkg
//  Description : Shared defaults, period constant and dead-time FSM state
//                encoding for the counter-comparator DPWM back end.
//  Revision    : 1.0 - initial release
// ============================================================================
package dpwm_pkg;

  // Default period counter / duty width (period = 2**CNT_W_DEF clocks).
  localparam int CNT_W_DEF = 6;
  // Default dead-time setting width.
  localparam int DT_W_DEF  = 3;
  // Last count of a period at the default width.
  localparam int PERIOD_LAST_DEF = (1 << CNT_W_DEF) - 1;

  // Dead-time FSM states. Gate outputs are decoded directly from the state.
  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_LS_ON   = 3'd1,
    ST_DT_RISE = 3'd2,
    ST_HS_ON   = 3'd3,
    ST_DT_FALL = 3'd4
  } dt_state_e;

endpackage
`default_nettype wire

// File: rtl/dpwm_deadtime_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dpwm_deadtime_gen
//  Description : Dead-time FSM and dead counter. Turns the raw comparator
//                output into non-overlapping high-side/low-side gate drives.
//                Moore machine: hs/ls are decoded from the state register.
//  Ports       : clk_in, rst  - clock, synchronous active-high reset
//                start        - period boundary strobe; releases ST_OFF
//                raw          - comparator output (cnt < duty_q)
//                dt_q         - dead time in clocks, stable within a period
//                hs, ls       - gate drives, never both high
//  Revision    : 1.0 - initial release
// ============================================================================
module dpwm_deadtime_gen
  import dpwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            start,
  input  logic            raw,
  input  logic [DT_W-1:0] dt_q,
  output logic            hs,
  output logic            ls
);

  dt_state_e       state_q, state_d;
  logic [DT_W-1:0] dead_q, dead_d;
  logic            dt_zero;

  assign dt_zero = (dt_q == '0);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_OFF;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    case (state_q)
      ST_OFF: begin
        if (start) state_d = ST_LS_ON;
      end
      ST_LS_ON: begin
        if (raw) begin
          if (dt_zero) begin
            state_d = ST_HS_ON;
          end else begin
            // The entry cycle itself counts as the first dead clock.
            state_d = ST_DT_RISE;
            dead_d  = dt_q - DT_W'(1);
          end
        end
      end
      ST_DT_RISE: begin
        // A pulse shorter than the dead band is swallowed: HS never fires.
        if (!raw)                state_d = ST_LS_ON;
        else if (dead_q == '0)   state_d = ST_HS_ON;
        else                     dead_d  = dead_q - DT_W'(1);
      end
      ST_HS_ON: begin
        if (!raw) begin
          if (dt_zero) begin
            state_d = ST_LS_ON;
          end else begin
            state_d = ST_DT_FALL;
            dead_d  = dt_q - DT_W'(1);
          end
        end
      end
      ST_DT_FALL: begin
        if (raw)                 state_d = ST_HS_ON;
        else if (dead_q == '0)   state_d = ST_LS_ON;
        else                     dead_d  = dead_q - DT_W'(1);
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  assign hs = (state_q == ST_HS_ON);
  assign ls = (state_q == ST_LS_ON);

endmodule
`default_nettype wire

// File: rtl/dpwm_deadtime.sv
`default_nettype none
// ============================================================================
//  Module      : dpwm_deadtime
//  Description : Counter-comparator DPWM back end with programmable dead
//                time. Free-running period counter, duty/dead-time latched at
//                the last count of each period, raw compare, dead-time FSM.
//  Ports       : clk_in, rst  - clock, synchronous active-high reset
//                duty         - high-side on-count per period
//                dead_time    - dead clocks inserted at each gate edge
//                pwm_hs/ls    - complementary gate drives (registered)
//                period_end   - one-cycle strobe at cnt == 2**CNT_W-1
//                cnt          - current period count
//  Build macro : DPWM_DEADTIME_EN - when defined, dead_time is honoured;
//                otherwise dead time is held at zero and dead_time ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module dpwm_deadtime
  import dpwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DT_W  = DT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [CNT_W-1:0] duty,
  input  logic [DT_W-1:0]  dead_time,
  output logic             pwm_hs,
  output logic             pwm_ls,
  output logic             period_end,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] PERIOD_LAST = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [DT_W-1:0]  dt_q, dt_d;
  logic             raw;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
      dt_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      dt_q   <= dt_d;
    end
  end

  assign period_end = (cnt_q == PERIOD_LAST);

  always_comb begin
    // Natural wrap at 2**CNT_W; no terminal stall.
    cnt_d  = cnt_q + CNT_W'(1);
    duty_d = period_end ? duty : duty_q;
`ifdef DPWM_DEADTIME_EN
    dt_d   = period_end ? dead_time : dt_q;
`else
    dt_d   = '0;
`endif
  end

`ifndef DPWM_DEADTIME_EN
  logic unused_dead_time;
  assign unused_dead_time = ^dead_time;
`endif

  // duty_q == 2**CNT_W-1 still leaves one low cycle: 100% is unreachable.
  assign raw = (cnt_q < duty_q);

  dpwm_deadtime_gen #(
    .DT_W (DT_W)
  ) u_gen (
    .clk_in (clk_in),
    .rst    (rst),
    .start  (period_end),
    .raw    (raw),
    .dt_q   (dt_q),
    .hs     (pwm_hs),
    .ls     (pwm_ls)
  );

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dpwm_deadtime.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpwm_deadtime
//  Description : Self-checking bench for dpwm_deadtime. A closed-form
//                per-period waveform model feeds a scoreboard queue; a table
//                of duty/dead-time settings checks per-period on-time; hand
//                sequences cover mid-period duty change and mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dpwm_deadtime;

`ifdef DPWM_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic [5:0] duty   = '0;
  logic [2:0] dead_time = '0;
  logic       pwm_hs, pwm_ls, period_end;
  logic [5:0] cnt;

  dpwm_deadtime #(
    .CNT_W (6),
    .DT_W  (3)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .duty       (duty),
    .dead_time  (dead_time),
    .pwm_hs     (pwm_hs),
    .pwm_ls     (pwm_ls),
    .period_end (period_end),
    .cnt        (cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [5:0] cnt;
    logic       pe;
    logic       hs;
    logic       ls;
  } exp_t;

  typedef struct {
    logic [5:0] duty;
    logic [2:0] dt;
    int         on_dt;
    int         on_nodt;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   m_cnt = 0, m_duty = 0, m_dt = 0;
  bit   m_run = 1'b0;
  int   hs_acc = 0, hs_period = 0;
  vec_t vt[7];

  // Expected gates for count c of a period that started in LS_ON with
  // latched duty d and dead time t.
  function automatic exp_t model_out(input int c, input int d, input int t, input bit run);
    exp_t e;
    e.cnt = 6'(c);
    e.pe  = (c == 63);
    e.hs  = 1'b0;
    e.ls  = 1'b0;
    if (run) begin
      if (d == 0) begin
        e.ls = 1'b1;
      end else if (d > t) begin
        if (c >= t + 1 && c <= d)                                e.hs = 1'b1;
        else if (!((c >= 1 && c <= t) || (c >= d + 1 && c <= d + t))) e.ls = 1'b1;
      end else begin
        if (!(c >= 1 && c <= d)) e.ls = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
    if (rst) begin
      m_cnt = 0; m_duty = 0; m_dt = 0; m_run = 1'b0;
    end else begin
      if (m_cnt == 63) begin
        m_duty = int'(duty);
        m_dt   = DT_EN ? int'(dead_time) : 0;
        m_run  = 1'b1;
      end
      m_cnt = (m_cnt + 1) % 64;
    end
    sb_q.push_back(model_out(m_cnt, m_duty, m_dt, m_run));
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic run_to(input int c);
    for (int i = 0; i < 70 && m_cnt != c; i++) step();
    if (m_cnt != c) check("run_to_timeout", m_cnt, c);
  endtask

  // Step past the next period boundary so the current inputs are latched.
  task automatic settle();
    step();
    run_to(0);
  endtask

  // Run one full period and let the monitor close its on-time count.
  task automatic measure();
    step();
    run_to(0);
    @(negedge clk_in);
    #1;
  endtask

  always @(negedge clk_in) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_vec++;
      if ({cnt, period_end, pwm_hs, pwm_ls} !== {mon_e.cnt, mon_e.pe, mon_e.hs, mon_e.ls}) begin
        n_err++;
        $display("FAIL sb: got cnt=%0d pe=%b hs=%b ls=%b, expected cnt=%0d pe=%b hs=%b ls=%b",
                 cnt, period_end, pwm_hs, pwm_ls, mon_e.cnt, mon_e.pe, mon_e.hs, mon_e.ls);
      end
      if (mon_e.cnt == 6'd0) begin
        hs_period = hs_acc;
        hs_acc    = int'(pwm_hs);
      end else begin
        hs_acc    = hs_acc + int'(pwm_hs);
      end
    end
    n_vec++;
    if (pwm_hs && pwm_ls) begin
      n_err++;
      $display("FAIL overlap: got hs=%b ls=%b, expected never both high", pwm_hs, pwm_ls);
    end
  end

  initial begin
    vt[0] = '{6'd32, 3'd0, 32, 32};
    vt[1] = '{6'd32, 3'd3, 29, 32};
    vt[2] = '{6'd2,  3'd3,  0,  2};
    vt[3] = '{6'd16, 3'd7,  9, 16};
    vt[4] = '{6'd0,  3'd5,  0,  0};
    vt[5] = '{6'd1,  3'd1,  0,  1};
    vt[6] = '{6'd48, 3'd1, 47, 48};

    // Reset state
    rst = 1'b1; duty = 6'd32; dead_time = 3'd0;
    repeat (3) step();
    @(negedge clk_in); #1;
    check("rst_cnt", int'(cnt), 0);
    check("rst_hs", int'(pwm_hs), 0);
    check("rst_ls", int'(pwm_ls), 0);
    check("rst_pe", int'(period_end), 0);
    rst = 1'b0;

    // Table of steady-state settings
    for (int i = 0; i < 7; i++) begin
      duty      = vt[i].duty;
      dead_time = vt[i].dt;
      settle();
      measure();
      check($sformatf("on_time[%0d]", i), hs_period, DT_EN ? vt[i].on_dt : vt[i].on_nodt);
    end

    // Mid-period duty change only takes effect next period
    duty = 6'd10; dead_time = 3'd0;
    settle();
    run_to(20);
    duty = 6'd50;
    run_to(0);
    @(negedge clk_in); #1;
    check("keep_old_duty", hs_period, 10);
    measure();
    check("new_duty", hs_period, 50);

    // Reset while the high side is on
    dead_time = 3'd2;
    settle();
    run_to(40);
    @(negedge clk_in); #1;
    check("hs_at_40", int'(pwm_hs), 1);
    rst = 1'b1;
    step();
    @(negedge clk_in); #1;
    check("mid_rst_cnt", int'(cnt), 0);
    check("mid_rst_hs", int'(pwm_hs), 0);
    check("mid_rst_ls", int'(pwm_ls), 0);
    rst = 1'b0;
    step();
    run_to(0);
    @(negedge clk_in); #1;
    check("recover_ls", int'(pwm_ls), 1);
    measure();
    check("recover_on", hs_period, DT_EN ? 48 : 50);

    repeat (2) @(negedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
